// File: rtl/async_fifo_64w_16r.sv
// async_fifo_64w_16r
//   Width-converting FIFO: a 64-bit producer writes whole words and a 16-bit
//   consumer reads them back one lane at a time. Lane 0 (bits [15:0]) is read
//   first. Both sides share one clock. Levels and flags are derived purely
//   from the registered pointers, so they never depend combinationally on
//   wr_en or rd_en.
//
// Ports
//   clk            : clock for both sides
//   tb_rst         : asynchronous, active-high reset
//   wr_data        : write word
//   wr_en          : write request (ignored while wr_full)
//   wr_full        : storage holds 2**WR_DEPTH_WIDTH words
//   wr_water_level : occupied words (a partially read word still counts)
//   almost_full    : wr_water_level >= ALMOST_FULL_NUM
//   rd_en          : read request (ignored while rd_empty)
//   rd_data        : registered read unit, held when no read is accepted
//   rd_empty       : no unread units
//   rd_water_level : unread units
//   almost_empty   : rd_water_level <= ALMOST_EMPTY_NUM
module async_fifo_64w_16r #(
  parameter int WR_DEPTH_WIDTH   = 8,
  parameter int WR_DATA_WIDTH    = 64,
  parameter int RD_DEPTH_WIDTH   = 10,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int RATIO  = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int LANE_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int WORDS  = 1 << WR_DEPTH_WIDTH;

  localparam logic [WR_DEPTH_WIDTH:0] FULL_LEVEL = (WR_DEPTH_WIDTH+1)'(WORDS);
  localparam logic [WR_DEPTH_WIDTH:0] AF_LEVEL   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [RD_DEPTH_WIDTH:0] AE_LEVEL   = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [WR_DEPTH_WIDTH:0] wp;
  logic [RD_DEPTH_WIDTH:0] rp;

  logic [WR_DATA_WIDTH-1:0] mem [0:WORDS-1];

  logic wr_acc;
  logic rd_acc;
  logic [RATIO-1:0][RD_DATA_WIDTH-1:0] rd_lanes;

  // Levels from registered pointers; modulo arithmetic handles the wrap.
  // The write side compares against the word part of rp, so a word stays
  // occupied until its last lane has been read.
  always_comb begin
    rd_water_level = {wp, {LANE_W{1'b0}}} - rp;
    wr_water_level = wp - rp[RD_DEPTH_WIDTH:LANE_W];
    wr_full        = (wr_water_level == FULL_LEVEL);
    almost_full    = (wr_water_level >= AF_LEVEL);
    rd_empty       = (rd_water_level == '0);
    almost_empty   = (rd_water_level <= AE_LEVEL);
  end

  assign wr_acc   = wr_en && !wr_full;
  assign rd_acc   = rd_en && !rd_empty;
  assign rd_lanes = mem[rp[RD_DEPTH_WIDTH-1:LANE_W]];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp[WR_DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wp <= '0;
    end else if (wr_acc) begin
      wp <= wp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rp      <= '0;
      rd_data <= '0;
    end else if (rd_acc) begin
      rp      <= rp + 1'b1;
      rd_data <= rd_lanes[rp[LANE_W-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_64w_16r.sv
// Testbench for async_fifo_64w_16r: constant-expectation vector table,
// hand-written corner sequences, and randomized traffic compared against a
// queue-of-units reference model.
module tb_async_fifo_64w_16r;

  logic        clk;
  logic        tb_rst;
  logic [63:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic [8:0]  wr_water_level;
  logic        almost_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_empty;
  logic [10:0] rd_water_level;
  logic        almost_empty;

  async_fifo_64w_16r #(
    .WR_DEPTH_WIDTH   (8),
    .WR_DATA_WIDTH    (64),
    .RD_DEPTH_WIDTH   (10),
    .RD_DATA_WIDTH    (16),
    .ALMOST_FULL_NUM  (252),
    .ALMOST_EMPTY_NUM (4)
  ) dut (
    .clk            (clk),
    .tb_rst         (tb_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Reference model: FIFO of 16-bit units plus last value delivered.
  logic [15:0] mq[$];
  logic [15:0] m_rd;

  function automatic int m_rwl();
    return mq.size();
  endfunction

  // Writes are whole words, so occupied words = units rounded up.
  function automatic int m_wwl();
    return (mq.size() + 3) / 4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all();
    check("rd_water_level", 64'(rd_water_level), 64'(m_rwl()));
    check("wr_water_level", 64'(wr_water_level), 64'(m_wwl()));
    check("wr_full",        64'(wr_full),        64'(m_wwl() == 256));
    check("almost_full",    64'(almost_full),    64'(m_wwl() >= 252));
    check("rd_empty",       64'(rd_empty),       64'(m_rwl() == 0));
    check("almost_empty",   64'(almost_empty),   64'(m_rwl() <= 4));
    check("rd_data",        64'(rd_data),        64'(m_rd));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_empty"},     64'(rd_empty),       64'd1);
    check({tag, "_almost_empty"}, 64'(almost_empty),   64'd1);
    check({tag, "_wr_full"},      64'(wr_full),        64'd0);
    check({tag, "_almost_full"},  64'(almost_full),    64'd0);
    check({tag, "_wr_level"},     64'(wr_water_level), 64'd0);
    check({tag, "_rd_level"},     64'(rd_water_level), 64'd0);
    check({tag, "_rd_data"},      64'(rd_data),        64'd0);
  endtask

  // Drive one cycle, advance the model with the acceptance rules, compare.
  task automatic step(input logic we, input logic [63:0] wd, input logic re);
    bit wacc;
    bit racc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc = we && (m_wwl() < 256);
    racc = re && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (racc) m_rd = mq.pop_front();
    if (wacc) for (int i = 0; i < 4; i++) mq.push_back(wd[16*i +: 16]);
    check_all();
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic apply_reset(input int dur);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    tb_rst  = 1'b1;
    #(dur);
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    mq.delete();
    m_rd = '0;
  endtask

  typedef struct {
    logic        we;
    logic [63:0] wd;
    logic        re;
    int          rwl;
    int          wwl;
    logic [15:0] rdat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    int unsigned words;
    bit done;

    vecs[0] = '{1'b1, 64'h1111_2222_3333_4444, 1'b0, 4, 1, 16'h0000};
    vecs[1] = '{1'b0, 64'h0,                   1'b1, 3, 1, 16'h4444};
    vecs[2] = '{1'b0, 64'h0,                   1'b1, 2, 1, 16'h3333};
    vecs[3] = '{1'b0, 64'h0,                   1'b1, 1, 1, 16'h2222};
    vecs[4] = '{1'b0, 64'h0,                   1'b1, 0, 0, 16'h1111};
    vecs[5] = '{1'b0, 64'h0,                   1'b1, 0, 0, 16'h1111};
    vecs[6] = '{1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 4, 1, 16'h1111};
    vecs[7] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 7, 2, 16'hDDDD};
    vecs[8] = '{1'b0, 64'h0,                   1'b1, 6, 2, 16'hCCCC};

    tb_rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    m_rd = '0;

    // Reset
    apply_reset(200);
    check_reset_values("reset");

    // Fill: 257 beats, decrementing data, last one dropped.
    d = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 257; k++) begin
      step(1'b1, d, 1'b0);
      d = d - 64'd1;
      if (k == 250) check("fill_af_251", 64'(almost_full), 64'd0);
      if (k == 251) check("fill_af_252", 64'(almost_full), 64'd1);
      if (k == 254) check("fill_notfull_255", 64'(wr_full), 64'd0);
      if (k >= 255) begin
        check("fill_full",  64'(wr_full),        64'd1);
        check("fill_wwl",   64'(wr_water_level), 64'd256);
        check("fill_rwl",   64'(rd_water_level), 64'd1024);
      end
    end

    // Drain: 1025 reads, last one ignored.
    for (int k = 0; k < 1025; k++) begin
      step(1'b0, 64'h0, 1'b1);
      if (k < 4)     check("drain_first_word", 64'(rd_data), 64'hFFFF);
      if (k == 4)    check("drain_lane0_w1",   64'(rd_data), 64'hFFFE);
      if (k == 5)    check("drain_lane1_w1",   64'(rd_data), 64'hFFFF);
      if (k == 1018) check("drain_ae_5",       64'(almost_empty), 64'd0);
      if (k == 1019) check("drain_ae_4",       64'(almost_empty), 64'd1);
      if (k == 1022) check("drain_notempty",   64'(rd_empty), 64'd0);
      if (k >= 1023) begin
        check("drain_empty",    64'(rd_empty), 64'd1);
        check("drain_last_val", 64'(rd_data),  64'hFFFF);
      end
    end

    // Vector table: partial word, ignored reads, simultaneous traffic.
    apply_reset(20);
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      check($sformatf("vec%0d_rwl", i),   64'(rd_water_level), 64'(vecs[i].rwl));
      check($sformatf("vec%0d_wwl", i),   64'(wr_water_level), 64'(vecs[i].wwl));
      check($sformatf("vec%0d_rdat", i),  64'(rd_data),        64'(vecs[i].rdat));
      check($sformatf("vec%0d_empty", i), 64'(rd_empty),       64'(vecs[i].rwl == 0));
      check($sformatf("vec%0d_ae", i),    64'(almost_empty),   64'(vecs[i].rwl <= 4));
    end

    // Simultaneous read/write with 10 words stored.
    apply_reset(20);
    for (int k = 0; k < 10; k++) step(1'b1, {$urandom, $urandom}, 1'b0);
    check("sim_rwl_start", 64'(rd_water_level), 64'd40);
    check("sim_wwl_start", 64'(wr_water_level), 64'd10);
    for (int k = 0; k < 4; k++) step(1'b1, {$urandom, $urandom}, 1'b1);
    check("sim_rwl_end", 64'(rd_water_level), 64'd52);
    check("sim_wwl_end", 64'(wr_water_level), 64'd13);

    // Randomized mixed traffic.
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Wrap: 600 words streamed with continuous reads, crossing both pointer wraps.
    apply_reset(20);
    words = 0;
    done = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      logic we;
      we = ($urandom_range(0, 4) == 0);
      if (we && m_wwl() < 256) words++;
      step(we, {$urandom, $urandom}, 1'b1);
      if (words >= 600) done = 1'b1;
    end
    check("wrap_reached_600", 64'(done), 64'd1);
    for (int k = 0; k < 40; k++) step(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Reset mid-stream: values return before the next clock edge.
    #2;
    tb_rst = 1'b1;
    #1;
    check_reset_values("midrst");
    apply_reset(20);
    check_reset_values("postrst");

    step(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    check("post_wwl", 64'(wr_water_level), 64'd1);
    step(1'b0, 64'h0, 1'b1);
    check("post_lane0", 64'(rd_data), 64'hF00D);
    step(1'b0, 64'h0, 1'b1);
    check("post_lane1", 64'(rd_data), 64'hCAFE);
    step(1'b0, 64'h0, 1'b1);
    check("post_lane2", 64'(rd_data), 64'hBEEF);
    step(1'b0, 64'h0, 1'b1);
    check("post_lane3", 64'(rd_data), 64'hDEAD);
    check("post_empty", 64'(rd_empty), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/async_fifo_64w_16r.md
# async_fifo_64w_16r

Width-converting FIFO for the data path between a 64-bit producer and a 16-bit consumer. Storage is 256 × 64-bit words, read out as 1024 × 16-bit units. Both sides run on a single clock `clk`. Each side reports full/empty status, water levels and programmable almost flags.

## Interface
Parameters:
- `WR_DEPTH_WIDTH`, default 8: log2 of write depth (256 words).
- `WR_DATA_WIDTH`, default 64: write word width.
- `RD_DEPTH_WIDTH`, default 10: log2 of read depth (1024 units).
- `RD_DATA_WIDTH`, default 16: read unit width.
  - Ratio R = WR_DATA_WIDTH / RD_DATA_WIDTH = 4.
  - RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + log2(R).
- `ALMOST_FULL_NUM`, default 252: write-side almost-full threshold, in words.
- `ALMOST_EMPTY_NUM`, default 4: read-side almost-empty threshold, in units.

Ports:
- `clk`, in, 1: clock for both write and read sides.
- `tb_rst`, in, 1: reset, asynchronous, active-high; clock `clk`.
- `wr_data`, in, 64: write word.
- `wr_en`, in, 1: write request.
- `wr_full`, out, 1: FIFO holds 256 words.
- `wr_water_level`, out, 9: occupied words, 0..256.
- `almost_full`, out, 1: wr_water_level ≥ ALMOST_FULL_NUM.
- `rd_en`, in, 1: read request.
- `rd_data`, out, 16: read unit.
- `rd_empty`, out, 1: no unread units.
- `rd_water_level`, out, 11: unread units, 0..1024.
- `almost_empty`, out, 1: rd_water_level ≤ ALMOST_EMPTY_NUM.

## Operation
Pointers:
- Write pointer wp, 9 bits: counts accepted words, with wrap bit.
- Read pointer rp, 11 bits: counts accepted units, with wrap bit.
- Memory array is 256 × 64.

Write path:
- Accepted when wr_en=1 and wr_full=0.
- Accepted word stored at mem[wp[7:0]]; wp increments.
- Writes while full are dropped silently: no pointer or memory change.

Read path:
- Accepted when rd_en=1 and rd_empty=0.
- Word selected by mem[rp[9:2]]; lane selected by rp[1:0].
- Lane 0 = bits [15:0] (least-significant first), lane 3 = bits [63:48].
- Selected lane is registered into rd_data; rp increments.
- Reads while empty are ignored; rd_data holds its previous value.

Level arithmetic (modulo pointer width, computed from registered pointers):
- rd_water_level = {wp,2'b00} − rp.
- wr_water_level = wp − rp[10:2].
- A partially consumed word still counts as occupied for the write side.
- wr_full = (wr_water_level == 256).
- rd_empty = (rd_water_level == 0).

Simultaneous read and write in the same cycle: both take effect. Levels reflect the net change.

Pointer wrap:
- wp wraps 511→0 and rp wraps 2047→0 naturally.
- The wrap bit disambiguates full from empty.

Reset (tb_rst=1):
- wp=0, rp=0, rd_data=0.
- Outputs: wr_full=0, wr_water_level=0, almost_full=0, rd_empty=1, rd_water_level=0, almost_empty=1.
- Memory contents are not reset.
- Reset mid-operation discards all contents immediately.

## Timing
- Accepted write at edge N: rd_water_level +4, wr_water_level +1, flags updated, all visible after edge N.
- Data written at edge N is readable by an rd_en sampled at edge N+1 (one-cycle write-to-read latency).
- Accepted read at edge N: rd_data valid after edge N and stable through edge N+1. There is no output register stage.
- Status flags are combinational from the pointer registers. They do not depend combinationally on wr_en or rd_en.
- Throughput: one write and one read per cycle.

## Test plan
- **Reset:** assert tb_rst for 200 ns.
  - Required: rd_empty=1, almost_empty=1, wr_full=0, both levels 0, rd_data=0.
- **Fill:** write 257 consecutive beats, data starting 0xFFFF_FFFF_FFFF_FFFF and decrementing by 1.
  - After 252 words: almost_full=1.
  - After 256 words: wr_full=1, wr_water_level=256, rd_water_level=1024.
  - 257th write dropped: levels unchanged.
- **Drain:** 1025 consecutive reads.
  - rd_data sequence: FFFF, FFFF, FFFF, FFFF, then FFFE, FFFF, FFFF, FFFF, … (LSB lane first).
  - Each unit valid the cycle after its accepted read.
  - After 1020 reads: almost_empty=1. After 1024 reads: rd_empty=1.
  - 1025th read ignored; rd_data holds the last value.
- **Partial word:** write 1 word, read 1 unit.
  - Required: rd_water_level=3, wr_water_level=1.
  - 3 more reads → rd_empty=1, wr_water_level=0.
- **Simultaneous:** with 10 words stored, assert wr_en and rd_en together for 4 cycles.
  - Required: rd_water_level 40→52, wr_water_level 10→13.
- **Wrap and reset:** run 600 words through with streaming reads; confirm order across the pointer wrap. Assert tb_rst mid-stream.
  - Required: immediate return to reset values; subsequent write/read works from address 0.
